// File: rtl/phy_rx_serial_paralelo_pkg.sv
// Shared constants and state type for the PHY receive deserializer.
package phy_pkg;
  localparam logic [7:0] COMMA_SYM = 8'hBC;
  localparam int         LANES     = 4;

  typedef enum logic [1:0] {
    HUNT,
    ALIGN,
    LOCK
  } rx_state_t;
endpackage

// File: rtl/phy_rx_serial_paralelo_if.sv
// Line-side and lane-side signals of the PHY receive deserializer.
// idle_out exists only when PHY_RX_IDLE_OUT_EN is defined.
interface phy_rx_serial_paralelo_if;
  logic       serial_in;
  logic       active;
  logic [7:0] data_out0;
  logic [7:0] data_out1;
  logic [7:0] data_out2;
  logic [7:0] data_out3;
  logic       valid0;
  logic       valid1;
  logic       valid2;
  logic       valid3;
  logic       word_strobe;
`ifdef PHY_RX_IDLE_OUT_EN
  logic       idle_out;
`endif

  modport master (
`ifdef PHY_RX_IDLE_OUT_EN
    output idle_out,
`endif
    input  serial_in,
    output active,
    output data_out0, data_out1, data_out2, data_out3,
    output valid0, valid1, valid2, valid3,
    output word_strobe
  );

  modport slave (
`ifdef PHY_RX_IDLE_OUT_EN
    input  idle_out,
`endif
    output serial_in,
    input  active,
    input  data_out0, data_out1, data_out2, data_out3,
    input  valid0, valid1, valid2, valid3,
    input  word_strobe
  );
endinterface

// File: rtl/phy_rx_serial_paralelo_ser_par_byte.sv
// Serial-to-byte front end: MSB-first shifter and bit counter with a realign hold.
module ser_par_byte (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       realign,
  output logic [7:0] sh,
  output logic       byte_rdy
);
  logic [2:0] bit_cnt;

  // realign pins the counter at 0 so the first bit after a hunt match is bit 0 of the next byte
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else begin
      sh      <= {sh[6:0], serial_in};
      bit_cnt <= realign ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  assign byte_rdy = (bit_cnt == 3'd7);
endmodule

// File: rtl/phy_rx_serial_paralelo.sv
// PHY receive deserializer: comma hunt/align/lock FSM and round-robin 4-lane unstriping.
// Optional idle_out flag is built only when PHY_RX_IDLE_OUT_EN is defined.
module phy_rx_serial_paralelo
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA   = COMMA_SYM,
  parameter int         SYNC_BC = 4
) (
  input logic                      clk_4f,
  input logic                      reset,
  phy_rx_serial_paralelo_if.master bus
);
  // state | meaning
  // HUNT  | sliding COMMA search on every bit
  // ALIGN | byte-aligned, counting consecutive aligned commas
  // LOCK  | locked, each byte written to the next lane

  localparam logic [3:0] SYNC_LIMIT = 4'(SYNC_BC);

  rx_state_t  state;
  logic [3:0] bc_cnt;
  logic [3:0] bc_next;
  logic [1:0] lane;
  logic       active;
  logic       word_strobe;
  logic [7:0] lane_data  [LANES];
  logic       lane_valid [LANES];
  logic [7:0] sh;
  logic       byte_rdy;
  logic       is_comma;
`ifdef PHY_RX_IDLE_OUT_EN
  logic       idle_q;
`endif

  ser_par_byte u_ser_par_byte (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .serial_in(bus.serial_in),
    .realign  (state == HUNT),
    .sh       (sh),
    .byte_rdy (byte_rdy)
  );

  assign is_comma = (sh == COMMA);
  assign bc_next  = bc_cnt + 4'd1;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      bc_cnt      <= '0;
      lane        <= '0;
      active      <= 1'b0;
      word_strobe <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        lane_data[k]  <= '0;
        lane_valid[k] <= 1'b0;
      end
`ifdef PHY_RX_IDLE_OUT_EN
      idle_q      <= 1'b0;
`endif
    end else begin
      word_strobe <= 1'b0;
      case (state)
        HUNT: begin
          if (is_comma) begin
            bc_cnt <= 4'd1;
            state  <= ALIGN;
          end
        end
        ALIGN: begin
          if (byte_rdy) begin
            if (is_comma) begin
              bc_cnt <= bc_next;
              // >= lets SYNC_BC=1 lock on the first aligned comma after the hunt match
              if (bc_next >= SYNC_LIMIT) begin
                state  <= LOCK;
                active <= 1'b1;
                lane   <= '0;
              end
            end else begin
              bc_cnt <= '0;
              state  <= HUNT;
            end
          end
        end
        LOCK: begin
          if (byte_rdy) begin
            lane_data[lane]  <= sh;
            lane_valid[lane] <= !is_comma;
            lane             <= lane + 2'd1;
            word_strobe      <= (lane == 2'd3);
`ifdef PHY_RX_IDLE_OUT_EN
            idle_q           <= is_comma;
`endif
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign bus.active      = active;
  assign bus.word_strobe = word_strobe;
  assign bus.data_out0   = lane_data[0];
  assign bus.data_out1   = lane_data[1];
  assign bus.data_out2   = lane_data[2];
  assign bus.data_out3   = lane_data[3];
  assign bus.valid0      = lane_valid[0];
  assign bus.valid1      = lane_valid[1];
  assign bus.valid2      = lane_valid[2];
  assign bus.valid3      = lane_valid[3];
`ifdef PHY_RX_IDLE_OUT_EN
  assign bus.idle_out    = idle_q;
`endif
endmodule

// File: tb/tb_phy_rx_serial_paralelo.sv
// Directed bench for the PHY receive deserializer with a per-byte expectation scoreboard.
// Checks idle_out as well when PHY_RX_IDLE_OUT_EN is defined.
module tb_phy_rx_serial_paralelo;
  import phy_pkg::*;

  logic clk_4f = 1'b0;
  logic reset;

  phy_rx_serial_paralelo_if bus ();

  phy_rx_serial_paralelo dut (
    .clk_4f(clk_4f),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct {
    bit         act_pre;
    bit         act_post;
    bit         wr;
    logic [1:0] lane;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] m_data  [4];
  logic       m_valid [4];
  logic       m_idle;
  logic [1:0] m_lane;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] get_data(input int k);
    case (k)
      0:       return bus.data_out0;
      1:       return bus.data_out1;
      2:       return bus.data_out2;
      default: return bus.data_out3;
    endcase
  endfunction

  function automatic logic get_valid(input int k);
    case (k)
      0:       return bus.valid0;
      1:       return bus.valid1;
      2:       return bus.valid2;
      default: return bus.valid3;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_data[k]  = 8'h00;
      m_valid[k] = 1'b0;
    end
    m_idle = 1'b0;
    m_lane = 2'd0;
    sb.delete();
  endtask

  task automatic check_lanes(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s data_out%0d", tag, k), 32'(get_data(k)), 32'(m_data[k]));
      chk($sformatf("%s valid%0d", tag, k), 32'(get_valid(k)), 32'(m_valid[k]));
    end
  endtask

  // Drives one byte MSB-first; while doing so, checks the previous byte's expected effect.
  task automatic send_byte(input logic [7:0] b, input bit pre, input bit post, input bit wr,
                           input int nbits = 8);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_4f);
      if (i == 0 && sb.size() > 0) begin
        chk("active before update", 32'(bus.active), 32'(sb[0].act_pre));
        chk("word_strobe low", 32'(bus.word_strobe), 32'(0));
      end
      if (i == 1 && sb.size() > 0) begin
        e = sb.pop_front();
        if (e.wr) begin
          m_data[e.lane]  = e.data;
          m_valid[e.lane] = (e.data != COMMA_SYM);
          m_idle          = (e.data == COMMA_SYM);
        end
        chk("active after update", 32'(bus.active), 32'(e.act_post));
        chk("word_strobe", 32'(bus.word_strobe), 32'(e.wr && e.lane == 2'd3));
        check_lanes($sformatf("byte %0h", e.data));
`ifdef PHY_RX_IDLE_OUT_EN
        chk("idle_out", 32'(bus.idle_out), 32'(m_idle));
`endif
      end
      bus.serial_in = b[7-i];
    end
    if (nbits == 8) begin
      e.act_pre  = pre;
      e.act_post = post;
      e.wr       = wr;
      e.lane     = m_lane;
      e.data     = b;
      sb.push_back(e);
      if (wr) m_lane = m_lane + 2'd1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk($sformatf("%s active", tag), 32'(bus.active), 32'(0));
    chk($sformatf("%s word_strobe", tag), 32'(bus.word_strobe), 32'(0));
    check_lanes(tag);
`ifdef PHY_RX_IDLE_OUT_EN
    chk($sformatf("%s idle_out", tag), 32'(bus.idle_out), 32'(0));
`endif
  endtask

  initial begin
    logic [2:0] junk;
    reset         = 1'b1;
    bus.serial_in = 1'b0;
    model_clear();
    repeat (2) @(negedge clk_4f);
    check_reset_state("reset");
    reset = 1'b0;

    // three junk bits, then four commas; lock one edge after the 4th comma
    junk = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_4f);
      bus.serial_in = junk[2-i];
    end
    send_byte(8'hBC, 0, 0, 0);
    send_byte(8'hBC, 0, 0, 0);
    send_byte(8'hBC, 0, 0, 0);
    send_byte(8'hBC, 0, 1, 0);

    send_byte(8'h00, 1, 1, 1);
    send_byte(8'hEE, 1, 1, 1);
    send_byte(8'hFF, 1, 1, 1);
    send_byte(8'hFD, 1, 1, 1);

    send_byte(8'hFD, 1, 1, 1);
    send_byte(8'hBC, 1, 1, 1);
    send_byte(8'hAA, 1, 1, 1);
    send_byte(8'h12, 1, 1, 1);
    send_byte(8'h11, 1, 1, 1);

    // comma then data: idle flag follows the lane writes
    send_byte(8'hBC, 1, 1, 1);
    send_byte(8'h12, 1, 1, 1);

    // reset in the middle of a locked byte
    send_byte(8'hA5, 1, 1, 1, 4);
    #2;
    reset         = 1'b1;
    bus.serial_in = 1'b0;
    #1;
    chk("async reset active", 32'(bus.active), 32'(0));
    model_clear();
    @(negedge clk_4f);
    check_reset_state("mid-lock reset");
    reset = 1'b0;

    // broken comma run returns to hunt; four fresh commas needed
    send_byte(8'hBC, 0, 0, 0);
    send_byte(8'hBC, 0, 0, 0);
    send_byte(8'h5A, 0, 0, 0);
    send_byte(8'hBC, 0, 0, 0);
    send_byte(8'hBC, 0, 0, 0);
    send_byte(8'hBC, 0, 0, 0);
    send_byte(8'hBC, 0, 1, 0);
    send_byte(8'h3C, 1, 1, 1);
    send_byte(8'h77, 1, 1, 1);
    send_byte(8'h00, 1, 1, 1, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
